// File: rtl/fetch_aligner.sv
// Instruction fetch aligner: turns word-aligned memory reads into a stream of
// 16-bit and 32-bit instructions at halfword-aligned PCs.
module fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic [31:0] pc_next_seq
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t      r_state,     w_state_next;
    logic [1:0]  r_count,     w_count_next;
    logic [47:0] r_buf,       w_buf_next;      // hw0 in [15:0], hw2 in [47:32]
    logic [29:0] r_fetch_ptr, w_fetch_ptr_next;
    logic        r_drop_low,  w_drop_low_next;
    logic [31:0] r_inst_pc,   w_inst_pc_next;

    logic [15:0] w_hw0;
    logic        w_hw0_is_c;
    logic        w_fire;
    logic        w_fill;
    logic [1:0]  w_cons_n;
    logic [1:0]  w_fill_n;
    logic [1:0]  w_surv;
    logic [1:0]  w_count_upd;
    logic [31:0] w_fill_data;
    logic [47:0] w_shifted;
    logic [63:0] w_merged;

    assign w_hw0      = r_buf[15:0];
    assign w_hw0_is_c = (w_hw0[1:0] != 2'b11);

    // An empty buffer holds zeros, which would decode as compressed; mask that.
    assign inst_is_c   = (r_count != 2'd0) && w_hw0_is_c;
    assign inst_valid  = !flush && (((r_count >= 2'd1) && w_hw0_is_c) || (r_count >= 2'd2));
    assign inst        = inst_is_c ? {16'h0000, w_hw0} : r_buf[31:0];
    assign inst_pc     = r_inst_pc;
    assign pc_next_seq = r_inst_pc + (inst_is_c ? 32'd2 : 32'd4);
    assign mem_req     = (r_state == S_REQ);
    assign mem_addr    = {r_fetch_ptr, 2'b00};

    assign w_fire      = inst_valid && inst_ready;
    assign w_fill      = (r_state == S_REQ) && mem_ready;
    assign w_cons_n    = w_fire ? (inst_is_c ? 2'd1 : 2'd2) : 2'd0;
    assign w_fill_n    = w_fill ? (r_drop_low ? 2'd1 : 2'd2) : 2'd0;
    assign w_surv      = r_count - w_cons_n;
    assign w_count_upd = w_surv + w_fill_n;
    assign w_fill_data = !w_fill    ? 32'h0
                       : r_drop_low ? {16'h0000, mem_rdata[31:16]}
                       :              mem_rdata;

    // Slots at or above the count are kept zero, so new halfwords can be ORed in
    // directly behind the survivors.
    assign w_shifted = r_buf >> {w_cons_n, 4'b0000};
    assign w_merged  = {16'h0000, w_shifted} | ({32'h0, w_fill_data} << {w_surv, 4'b0000});

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next     = r_state;
        w_count_next     = r_count;
        w_buf_next       = r_buf;
        w_fetch_ptr_next = r_fetch_ptr;
        w_drop_low_next  = r_drop_low;
        w_inst_pc_next   = r_inst_pc;

        if (flush) begin
            w_state_next     = S_IDLE;
            w_count_next     = 2'd0;
            w_buf_next       = '0;
            w_inst_pc_next   = {flush_pc[31:1], 1'b0};
            w_fetch_ptr_next = flush_pc[31:2];
            w_drop_low_next  = flush_pc[1];
        end else begin
            w_buf_next   = w_merged[47:0];
            w_count_next = w_count_upd;
            if (w_fire) begin
                w_inst_pc_next = pc_next_seq;
            end
            if (w_fill) begin
                w_fetch_ptr_next = r_fetch_ptr + 30'd1;
                w_drop_low_next  = 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (r_count <= 2'd1) begin
                        w_state_next = S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        w_state_next = (w_count_upd <= 2'd1) ? S_REQ : S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the small halfword buffer is reset too, which keeps
    // inst at zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= 2'd0;
            r_buf       <= '0;
            r_fetch_ptr <= RESET_PC[31:2];
            r_drop_low  <= RESET_PC[1];
            r_inst_pc   <= {RESET_PC[31:1], 1'b0};
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_buf       <= w_buf_next;
            r_fetch_ptr <= w_fetch_ptr_next;
            r_drop_low  <= w_drop_low_next;
            r_inst_pc   <= w_inst_pc_next;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner: aligned, compressed, straddling,
// flush and backpressure scenarios against a simple zero-wait memory that can be stalled.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;
    logic [31:0] pc_next_seq;

    logic [31:0] mem_w [0:127];
    logic        mem_hold;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_ready = mem_req && !mem_hold;
    assign mem_rdata = mem_w[mem_addr[8:2]];

    fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_is_c   (inst_is_c),
        .pc_next_seq (pc_next_seq)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 128; i++) mem_w[i] = 32'h0000_0013;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!inst_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    endtask

    // Waits for a presented instruction, checks it, and steps one cycle
    // (the instruction is consumed on that edge when inst_ready=1).
    task automatic expect_inst(input string tag, input logic [31:0] e_inst,
                               input logic [31:0] e_pc, input logic e_c,
                               input logic [31:0] e_nseq);
        wait_valid(tag);
        check({tag, "_inst"}, inst, e_inst);
        check({tag, "_pc"}, inst_pc, e_pc);
        check({tag, "_c"}, 32'(inst_is_c), 32'(e_c));
        check({tag, "_nseq"}, pc_next_seq, e_nseq);
        @(negedge clk);
    endtask

    // Parks the DUT in REQ, asserts reset mid-cycle, and releases it on a negedge.
    task automatic do_reset();
        mem_hold   = 1'b1;
        inst_ready = 1'b1;
        flush      = 1'b0;
        @(negedge clk);
        wait_req("prerst");
        #2 rst_n = 1'b0;
        #1 check("rst_drops_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        inst_ready = 1'b0;
        mem_clear();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        flush_pc   = 32'h0;
        inst_ready = 1'b0;
        mem_hold   = 1'b1;
        mem_clear();
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_is_c", 32'(inst_is_c), 32'd0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_nseq", pc_next_seq, 32'h4);

        // Aligned 32-bit stream; first request appears in the second cycle.
        mem_w[0] = 32'h0050_0093;
        mem_w[1] = 32'h00A0_0113;
        rst_n = 1'b1;
        check("rel_req_c1", 32'(mem_req), 32'd0);
        @(negedge clk);
        check("rel_req_c2", 32'(mem_req), 32'd1);
        check("rel_addr_c2", mem_addr, 32'h0);
        mem_hold   = 1'b0;
        inst_ready = 1'b1;
        expect_inst("al0", 32'h0050_0093, 32'h0, 1'b0, 32'h4);
        expect_inst("al1", 32'h00A0_0113, 32'h4, 1'b0, 32'h8);
        expect_inst("al2", 32'h0000_0013, 32'h8, 1'b0, 32'hC);

        // Compressed pair in one word.
        do_reset();
        mem_w[0]   = 32'h4509_4505;
        mem_hold   = 1'b0;
        inst_ready = 1'b1;
        expect_inst("cp0", 32'h0000_4505, 32'h0, 1'b1, 32'h2);
        expect_inst("cp1", 32'h0000_4509, 32'h2, 1'b1, 32'h4);
        expect_inst("cp2", 32'h0000_0013, 32'h4, 1'b0, 32'h8);

        // 32-bit instruction straddling a word boundary; second word withheld.
        do_reset();
        mem_w[0]   = 32'h0093_4505;
        mem_w[1]   = 32'hDEAD_0050;
        inst_ready = 1'b1;
        wait_req("st");
        mem_hold = 1'b0;
        @(negedge clk);
        mem_hold = 1'b1;
        expect_inst("st0", 32'h0000_4505, 32'h0, 1'b1, 32'h2);
        repeat (4) @(negedge clk);
        check("st_wait_valid", 32'(inst_valid), 32'd0);
        check("st_wait_req", 32'(mem_req), 32'd1);
        check("st_wait_addr", mem_addr, 32'h4);
        mem_hold = 1'b0;
        expect_inst("st1", 32'h0050_0093, 32'h2, 1'b0, 32'h6);
        expect_inst("st2", 32'h0000_DEAD, 32'h6, 1'b1, 32'h8);

        // Unaligned flush target drops the low halfword of the first word.
        do_reset();
        mem_w[0]  = 32'h0050_0093;
        mem_w[64] = 32'h4505_FFFF;
        mem_hold  = 1'b0;
        wait_valid("uf_pre");
        flush    = 1'b1;
        flush_pc = 32'h0000_0102;
        #1 check("uf_gate", 32'(inst_valid), 32'd0);
        @(negedge clk);
        flush      = 1'b0;
        inst_ready = 1'b1;
        wait_req("uf");
        check("uf_addr", mem_addr, 32'h100);
        expect_inst("uf0", 32'h0000_4505, 32'h102, 1'b1, 32'h104);
        expect_inst("uf1", 32'h0000_0013, 32'h104, 1'b0, 32'h108);

        // Backpressure: decoder stalls while memory is always ready.
        do_reset();
        mem_w[0] = 32'h4509_4505;
        mem_w[1] = 32'h00A0_0113;
        mem_w[2] = 32'h4511_450D;
        mem_hold = 1'b0;
        begin
            int reads = 0;
            repeat (12) begin
                @(negedge clk);
                if (mem_req && mem_ready) reads++;
            end
            check("bp_reads_le2", 32'(reads <= 2), 32'd1);
        end
        check("bp_valid", 32'(inst_valid), 32'd1);
        check("bp_hold_inst", inst, 32'h0000_4505);
        inst_ready = 1'b1;
        expect_inst("bp0", 32'h0000_4505, 32'h0, 1'b1, 32'h2);
        expect_inst("bp1", 32'h0000_4509, 32'h2, 1'b1, 32'h4);
        expect_inst("bp2", 32'h00A0_0113, 32'h4, 1'b0, 32'h8);
        expect_inst("bp3", 32'h0000_450D, 32'h8, 1'b1, 32'hA);
        expect_inst("bp4", 32'h0000_4511, 32'hA, 1'b1, 32'hC);

        // Flush coincident with mem_ready and inst_ready; bit 0 of the target ignored.
        do_reset();
        mem_w[0]  = 32'h4509_4505;
        mem_w[16] = 32'h00A0_0113;
        wait_req("fc");
        mem_hold = 1'b0;
        @(negedge clk);
        mem_hold   = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        wait_req("fc_setup");
        check("fc_setup_valid", 32'(inst_valid), 32'd1);
        check("fc_setup_pc", inst_pc, 32'h2);
        flush      = 1'b1;
        flush_pc   = 32'h0000_0041;
        mem_hold   = 1'b0;
        inst_ready = 1'b1;
        #1 check("fc_gate", 32'(inst_valid), 32'd0);
        check("fc_coincident_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        flush    = 1'b0;
        mem_hold = 1'b1;
        check("fc_abandon_req", 32'(mem_req), 32'd0);
        check("fc_empty", 32'(inst_valid), 32'd0);
        check("fc_pc", inst_pc, 32'h40);
        @(negedge clk);
        check("fc_req", 32'(mem_req), 32'd1);
        check("fc_addr", mem_addr, 32'h40);
        mem_hold = 1'b0;
        expect_inst("fc0", 32'h00A0_0113, 32'h40, 1'b0, 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_aligner.md
FETCH_ALIGNER -- requirements
Module: fetch_aligner

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch PC after reset; bit 0 is ignored.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  redirect request; one-cycle pulse from branch/jump resolution.
REQ-005 flush_pc  input  32  redirect target; bit 0 ignored; bit 1 may be set.
REQ-006 mem_req  output  1  instruction-memory read request.
REQ-007 mem_addr  output  32  word-aligned read address, bits [1:0] = 2'b00.
REQ-008 mem_ready  input  1  read completes this cycle; mem_rdata is valid.
REQ-009 mem_rdata  input  32  read word; the halfword at the lower address is in [15:0].
REQ-010 inst_valid  output  1  an aligned instruction is presented.
REQ-011 inst_ready  input  1  the decoder accepts the instruction.
REQ-012 inst  output  32  instruction; a compressed instruction is zero-extended to {16'h0, hw}.
REQ-013 inst_pc  output  32  halfword-aligned PC of inst.
REQ-014 inst_is_c  output  1  inst is 16-bit (inst[1:0] != 2'b11).
REQ-015 pc_next_seq  output  32  inst_pc+2 if inst_is_c, else inst_pc+4, modulo 2^32; this is the sequential input of the PC select mux.

Function
REQ-016 Buffer: 3 halfword slots hw0..hw2, occupancy count 0..3; hw0 is the oldest.
REQ-017 FSM states: IDLE (no outstanding read) and REQ (mem_req=1, mem_addr stable).
REQ-018 IDLE->REQ when count<=1 and flush=0; mem_req is 0 in IDLE.
REQ-019 In REQ, mem_req and mem_addr hold until mem_ready=1.
REQ-020 REQ on mem_ready: the fetch pointer advances by 4; stay in REQ if post-update count<=1, else go to IDLE.
REQ-021 Fill on mem_ready: append mem_rdata[15:0] then [31:16]; if drop_low=1, append only [31:16] and clear drop_low.
REQ-022 A request is issued only when count<=1, so the buffer never overflows; an overflow is a design error.
REQ-023 inst_valid=1 when flush=0 and either (count>=1 and hw0[1:0]!=2'b11) or count>=2.
REQ-024 32-bit case: inst={hw1,hw0}. Compressed case: inst={16'h0,hw0}.
REQ-025 Consume on inst_valid&inst_ready: shift out 1 slot (compressed) or 2 slots (32-bit); inst_pc <= pc_next_seq.
REQ-026 Fill and consume in the same cycle are both applied: new count = count + filled - consumed, with incoming halfwords placed after the survivors.
REQ-027 A 32-bit instruction straddling a word boundary is presented once both halfwords are buffered; no bubble is needed beyond the fill.
REQ-028 Outputs are combinational from registered state, except inst_valid, which is also gated by flush.
REQ-029 Flush has the highest priority, overriding fill and consume in the same cycle:
- count <= 0
- inst_pc <= {flush_pc[31:1],1'b0}
- fetch pointer <= flush_pc[31:2]
- drop_low <= flush_pc[1]
- state <= IDLE
- any mem_rdata in that cycle is discarded
REQ-030 A flush while in REQ abandons the read: mem_req falls the next cycle, and the memory must tolerate the abandoned request.

Reset
REQ-031 While rst_n=0:
- state=IDLE, count=0, hw0..hw2=16'h0
- mem_req=0, inst_valid=0
- inst_pc=RESET_PC with bit 0 cleared
- fetch pointer=RESET_PC[31:2], drop_low=RESET_PC[1]
- inst=32'h0, inst_is_c=0 (hw0[1:0]=2'b00 would decode as compressed, so this value is forced explicitly)
REQ-032 Reset asserted mid-read drops the request asynchronously.
REQ-033 After reset release, the first request is issued in the second cycle (IDLE->REQ).

Verification
REQ-034 Aligned 32-bit stream: RESET_PC=0, mem_ready=1 always, words 32'h00500093, 32'h00A00113, inst_ready=1 -> inst 32'h00500093 at inst_pc 0, then 32'h00A00113 at inst_pc 4, inst_is_c=0, pc_next_seq 4 and 8.
REQ-035 Compressed pair: word 32'h4509_4505 at address 0 -> inst 32'h00004505 at pc 0, then 32'h00004509 at pc 2, inst_is_c=1, pc_next_seq 2 then 4.
REQ-036 Straddle: word0=32'h0093_4505 and word1=32'hXXXX_0050 -> inst 32'h00004505 at pc 0; inst 32'h00500093 at pc 2 only after word1 returns; pc_next_seq=6.
REQ-037 Unaligned flush: flush=1 with flush_pc=32'h0000_0102, word at 32'h100 = 32'h4505_FFFF -> mem_addr=32'h100, the low half is dropped, inst 32'h00004505 at pc 32'h102, and inst_valid=0 during the flush cycle.
REQ-038 Backpressure: inst_ready=0 for 10 cycles while mem_ready=1 -> at most 2 reads complete, count<=3, no data lost; resuming inst_ready=1 delivers the instructions in order.
REQ-039 Flush coincident with mem_ready and inst_ready -> the returned word is discarded, no consume takes effect, and the next mem_addr equals flush_pc&~3.
